// File: rtl/core_s1_fetch.sv
// core_s1_fetch: stage-1 instruction fetch with credit-limited outstanding requests and a response FIFO.
// Optional feature: define LETC_CORE_S1_MISALIGN_TRAP_EN to turn misaligned redirects into
// misaligned-fetch fault entries instead of silently aligning the target PC.
module core_s1_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        s2_valid,
    input  logic        s2_ready,
    output logic [31:0] s2_instr,
    output logic [31:0] s2_pc,
    output logic        s2_access_fault,
    output logic        s2_misaligned_fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW+1:0] DEPTH_S = (CW + 2)'(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        af;
        logic        mf;
    } entry_t;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          halted_q, halted_d;
    logic          mis_pend_q, mis_pend_d;
    entry_t        fifo_q [DEPTH];
    entry_t        head;
    entry_t        wr_entry;
    logic [CW+1:0] used;
    logic          req_fire;
    logic          rsp_keep;
    logic          mis_push;
    logic          push;
    logic          pop;
    logic [31:0]   redir_pc;
    logic          redir_mis;

`ifdef LETC_CORE_S1_MISALIGN_TRAP_EN
    assign redir_mis = redirect_pc[1:0] != 2'b00;
    assign redir_pc  = redirect_pc;
    // The fault entry waits until stale responses can no longer need FIFO space.
    assign mis_push  = mis_pend_q && (({2'b00, count_q} + {2'b00, discard_q}) < DEPTH_S);
`else
    assign redir_mis = 1'b0;
    assign redir_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign mis_push  = 1'b0;
`endif

    // Every FIFO slot, live request and to-be-dropped response consumes one credit.
    assign used           = {2'b00, count_q} + {2'b00, inflight_q} + {2'b00, discard_q};
    assign imem_req_valid = rst_n && !halted_q && !mis_pend_q && !redirect_valid && (used < DEPTH_S);
    assign imem_req_addr  = fetch_pc_q & 32'hFFFF_FFFC;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (discard_q == '0);
    assign push           = !redirect_valid && (rsp_keep || mis_push);
    assign pop            = s2_valid && s2_ready;
    assign head           = fifo_q[rd_ptr_q];

    assign s2_valid            = rst_n && (count_q != '0);
    assign s2_instr            = s2_valid ? head.instr : 32'h0;
    assign s2_pc               = s2_valid ? head.pc : 32'h0;
    assign s2_access_fault     = s2_valid && head.af;
    assign s2_misaligned_fault = s2_valid && head.mf;

    assign wr_entry = mis_push ? '{instr: 32'h0, pc: rsp_pc_q, af: 1'b0, mf: 1'b1}
                               : '{instr: imem_rsp_fault ? 32'h0 : imem_rsp_data,
                                   pc: rsp_pc_q, af: imem_rsp_fault, mf: 1'b0};

    // Next-state: a redirect flushes everything and overrides every other event.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        halted_d   = halted_q;
        mis_pend_d = mis_pend_q;
        if (redirect_valid) begin
            fetch_pc_d = redir_pc;
            rsp_pc_d   = redir_pc;
            inflight_d = '0;
            discard_d  = discard_q + inflight_q - CW'(imem_rsp_valid);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            halted_d   = 1'b0;
            mis_pend_d = redir_mis;
        end else begin
            fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
            rsp_pc_d   = rsp_keep ? rsp_pc_q + 32'd4 : rsp_pc_q;
            inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_keep);
            discard_d  = discard_q - CW'(imem_rsp_valid && (discard_q != '0));
            count_d    = count_q + CW'(push) - CW'(pop);
            wr_ptr_d   = wr_ptr_q + AW'(push);
            rd_ptr_d   = rd_ptr_q + AW'(pop);
            halted_d   = halted_q || (rsp_keep && imem_rsp_fault) || mis_push;
            mis_pend_d = mis_pend_q && !mis_push;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            halted_q   <= 1'b0;
            mis_pend_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            halted_q   <= halted_d;
            mis_pend_q <= mis_pend_d;
        end
    end

    // FIFO storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (rst_n && push) fifo_q[wr_ptr_q] <= wr_entry;
    end

    // A kept response into a full FIFO means the memory broke the credit contract.
    always_ff @(posedge clk) begin
        if (rst_n && !redirect_valid) assert (!(rsp_keep && (count_q == DEPTH_C) && !pop));
    end
endmodule
